dct_unit_seq: RTL
=================

Name: dct_unit_seq

Overview:
- Sequencing controller for the 2-D DCT coefficient units inside fdct_zigzag.dct_mod.
- Accepts one 8x8 block as a stream of 64 samples and drives the MAC accumulator clear/enable plus the sample row/col index.
- After the multiplier pipeline drains, issues a single-cycle load strobe that captures the results into the enable-gated coef registers.
- Counts completed blocks and flags protocol errors.

Parameters:
- BLK_SIZE, 64, samples per block; row/col index is 8x8, fixed at 64.
- MAC_LAT, 3, multiplier/adder pipeline depth in cycles between the last acc_en and valid accumulator output; legal range 0..15.
- BCNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global clock enable; low freezes the block.
- dstrb  in  1  start-of-block marker, qualified by din_valid.
- din_valid  in  1  sample present on the datapath this cycle.
- din_ready  out  1  controller accepts a sample this cycle.
- acc_clr  out  1  clear the accumulators; same cycle as the first accepted sample.
- acc_en  out  1  accumulate enable; same cycle as each accepted sample.
- row  out  3  row index of the current sample (cnt[5:3]).
- col  out  3  column index of the current sample (cnt[2:0]).
- coef_ld  out  1  one-cycle enable to the coef DFFE registers.
- coef_vld  out  1  sticky flag: at least one block has been loaded.
- busy  out  1  high in ACCUM, DRAIN or LOAD.
- err  out  1  one-cycle registered error pulse.
- blk_cnt  out  BCNT_W  completed-block count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, drain counter=0.
  - All outputs 0 except din_ready=1.
  - No output toggles while rst_n is held low.
  - Reset in any state aborts the block; no coef_ld is issued.
- Accepted sample: acc = ena & din_valid & din_ready.
- acc_clr, acc_en and coef_ld are combinational from state, cnt and inputs, and are forced to 0 when ena=0.
- row/col equal cnt in IDLE and ACCUM.
- ena=0: state, counters and flags hold; err is not generated.
- IDLE (din_ready=1):
  - acc & dstrb: acc_clr=1, acc_en=1, cnt<=1, go to ACCUM.
  - acc & !dstrb: sample discarded, err pulses the next cycle, stay in IDLE.
- ACCUM (din_ready=1):
  - acc & !dstrb: acc_en=1, cnt<=cnt+1.
  - When the accepted sample has cnt=63: cnt<=0. If MAC_LAT>0, go to DRAIN with drain counter<=MAC_LAT-1; if MAC_LAT=0, go to LOAD.
  - acc & dstrb (early restart): err pulses the next cycle, acc_clr=1, acc_en=1, cnt<=1, stay in ACCUM. The aborted block is not counted.
  - din_valid=0: hold; gaps are unlimited.
- DRAIN (din_ready=0):
  - Drain counter decrements each enabled cycle.
  - At 0, go to LOAD.
  - Inputs are ignored; no err is raised.
- LOAD (din_ready=0):
  - coef_ld=1 for exactly one enabled cycle.
  - Registered updates: coef_vld<=1, blk_cnt<=blk_cnt+1 (wraps modulo 2^BCNT_W).
  - Next state is IDLE.
- Latency: last sample accepted at cycle T gives coef_ld at T+MAC_LAT+1 when ena is held high.
- err is registered: high for one cycle after the offending accepted sample.

Test Plan:
- Reset: rst_n=0 mid-stream, then release → din_ready=1, busy=0, blk_cnt=0, coef_vld=0, err=0, no coef_ld.
- Contiguous block, MAC_LAT=3:
  - Stimulus: dstrb+din_valid at cycle 0, din_valid held through cycle 63.
  - acc_clr only at cycle 0; acc_en cycles 0..63; row/col=7/7 at cycle 63.
  - din_ready=0 at cycles 64..67; coef_ld only at cycle 67.
  - blk_cnt=1 and coef_vld=1 from cycle 68.
- Gapped input: din_valid every other cycle for 64 samples → exactly 64 acc_en pulses, coef_ld 4 cycles after the last sample, row/col sequence 0/0..7/7 with no skips.
- Early restart: dstrb with sample 20 → err at the next cycle, acc_clr with that sample, row/col=0/0, and coef_ld only after 64 further samples; blk_cnt=1.
- ena gating: ena=0 for 5 cycles during DRAIN → coef_ld is delayed by exactly 5 cycles, no acc_en/coef_ld while ena=0, cnt held.
- Stray sample and reset in DRAIN:
  - din_valid without dstrb in IDLE → err pulse, no acc_en.
  - rst_n low in DRAIN → no coef_ld, blk_cnt unchanged at 0.

Source files
------------

// File: rtl/dct_unit_seq.sv
// Sequencing controller for one 2-D DCT coefficient unit: walks a 64-sample block,
// drives the MAC clear/enable and row/col index, then strobes the coef registers.
module dct_unit_seq #(
    parameter int BLK_SIZE = 64,
    parameter int MAC_LAT  = 3,
    parameter int BCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              dstrb,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              acc_clr,
    output logic              acc_en,
    output logic [2:0]        row,
    output logic [2:0]        col,
    output logic              coef_ld,
    output logic              coef_vld,
    output logic              busy,
    output logic              err,
    output logic [BCNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, LOAD} state_e;

    localparam logic [5:0] LAST_IDX = 6'(BLK_SIZE - 1);
    localparam logic [3:0] DRN_INIT = 4'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [3:0]          drn_q, drn_d;
    logic                vld_q, vld_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                err_q, err_d;
    logic                acc;
    logic [5:0]          idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drn_d     = drn_q;
        vld_d     = vld_q;
        bcnt_d    = bcnt_q;
        err_d     = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        coef_ld   = 1'b0;
        idx       = cnt_q;
        din_ready = (state_q == IDLE) || (state_q == ACCUM);
        // rst_n keeps the strobes quiet while reset is held, whatever the inputs do
        acc       = rst_n & ena & din_valid & din_ready;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (dstrb) begin
                        acc_clr = 1'b1;
                        acc_en  = 1'b1;
                        cnt_d   = 6'd1;
                        state_d = ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (acc) begin
                    acc_en = 1'b1;
                    if (dstrb) begin
                        // early restart: this sample becomes index 0 of a new block
                        err_d   = 1'b1;
                        acc_clr = 1'b1;
                        idx     = 6'd0;
                        cnt_d   = 6'd1;
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d = 6'd0;
                        if (MAC_LAT != 0) begin
                            drn_d   = DRN_INIT;
                            state_d = DRAIN;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DRAIN: begin
                if (ena) begin
                    if (drn_q == 4'd0) state_d = LOAD;
                    else               drn_d   = drn_q - 4'd1;
                end
            end
            LOAD: begin
                if (ena) begin
                    coef_ld = 1'b1;
                    vld_d   = 1'b1;
                    bcnt_d  = bcnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
            vld_q   <= 1'b0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            vld_q   <= vld_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    assign row      = idx[5:3];
    assign col      = idx[2:0];
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign coef_vld = vld_q;
    assign blk_cnt  = bcnt_q;

endmodule
